// File: rtl/cache_refill_ctrl.sv
// Line-miss refill controller: round-robin over p1/p2/w1, one outstanding fetch.
// Define REFILL_MERGE_EN to let one fetch clear every pending same-line miss.
module cache_refill_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 128,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_p1_i,
    input  logic              miss_p2_i,
    input  logic              miss_w1_i,
    input  logic [ADDR_W-1:0] miss_addr_p1_i,
    input  logic [ADDR_W-1:0] miss_addr_p2_i,
    input  logic [ADDR_W-1:0] miss_addr_w1_i,
    output logic              busy_p1_o,
    output logic              busy_p2_o,
    output logic              busy_w1_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic              mem_valid_i,
    input  logic [LINE_W-1:0] mem_rdata_i,
    output logic              fill_we_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [LINE_W-1:0] fill_data_o
);
    localparam int LA_W = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

    state_t                     state_q;
    logic [2:0]                 pend_q;
    logic [2:0][LA_W-1:0]       line_q;
    logic [1:0]                 ptr_q;
    logic [1:0]                 sel_q;
    logic                       mem_req_q;
    logic [ADDR_W-1:0]          mem_addr_q;
    logic                       fill_we_q;
    logic [ADDR_W-1:0]          fill_addr_q;
    logic [LINE_W-1:0]          fill_data_q;

    logic [2:0]                 miss;
    logic [2:0][LA_W-1:0]       miss_line;
    logic [1:0]                 sel_d;
    logic                       found;
    logic [2:0]                 clr;
    logic                       unused_lo;

    assign miss      = {miss_w1_i, miss_p2_i, miss_p1_i};
    assign miss_line = {miss_addr_w1_i[ADDR_W-1:OFFSET_W],
                        miss_addr_p2_i[ADDR_W-1:OFFSET_W],
                        miss_addr_p1_i[ADDR_W-1:OFFSET_W]};
    assign unused_lo = ^{miss_addr_p1_i[OFFSET_W-1:0],
                         miss_addr_p2_i[OFFSET_W-1:0],
                         miss_addr_w1_i[OFFSET_W-1:0]};

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Scan from farthest to nearest so the source closest to the pointer wins.
    always_comb begin
        found = 1'b0;
        sel_d = ptr_q;
        for (int i = 2; i >= 0; i--) begin
            int t;
            t = int'(ptr_q) + i;
            if (t >= 3) t = t - 3;
            if (pend_q[t]) begin
                found = 1'b1;
                sel_d = 2'(t);
            end
        end
    end

    always_comb begin
        clr = '0;
        if (state_q == S_FILL) begin
            clr[sel_q] = 1'b1;
`ifdef REFILL_MERGE_EN
            for (int j = 0; j < 3; j++) begin
                if (pend_q[j] && line_q[j] == fill_addr_q[ADDR_W-1:OFFSET_W])
                    clr[j] = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            line_q      <= '0;
            ptr_q       <= 2'd0;
            sel_q       <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            fill_we_q   <= 1'b0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (!pend_q[j] && miss[j]) begin
                    pend_q[j] <= 1'b1;
                    line_q[j] <= miss_line[j];
                end else if (clr[j]) begin
                    pend_q[j] <= 1'b0;
                end
            end
            fill_we_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_q     <= S_REQ;
                        sel_q       <= sel_d;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= {line_q[sel_d], {OFFSET_W{1'b0}}};
                        fill_addr_q <= {line_q[sel_d], {OFFSET_W{1'b0}}};
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_valid_i) begin
                        fill_data_q <= mem_rdata_i;
                        fill_we_q   <= 1'b1;
                        state_q     <= S_FILL;
                    end
                end
                S_FILL: begin
                    ptr_q   <= next_src(sel_q);
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_p1_o   = pend_q[0];
    assign busy_p2_o   = pend_q[1];
    assign busy_w1_o   = pend_q[2];
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign fill_we_o   = fill_we_q;
    assign fill_addr_o = fill_addr_q;
    assign fill_data_o = fill_data_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: a service-order model feeds expected
// fetches/fills; a memory responder and a fill monitor check them independently.
module tb_cache_refill_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         miss_p1, miss_p2, miss_w1;
    logic [31:0]  ma_p1, ma_p2, ma_w1;
    logic         busy_p1, busy_p2, busy_w1;
    logic         mem_req, mem_ack, mem_valid, fill_we;
    logic [31:0]  mem_addr, fill_addr;
    logic [127:0] mem_rdata, fill_data;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_p1_i(miss_p1), .miss_p2_i(miss_p2), .miss_w1_i(miss_w1),
        .miss_addr_p1_i(ma_p1), .miss_addr_p2_i(ma_p2),
        .miss_addr_w1_i(ma_w1),
        .busy_p1_o(busy_p1), .busy_p2_o(busy_p2), .busy_w1_o(busy_w1),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_ack_i(mem_ack), .mem_valid_i(mem_valid),
        .mem_rdata_i(mem_rdata),
        .fill_we_o(fill_we), .fill_addr_o(fill_addr),
        .fill_data_o(fill_data)
    );

    wire [2:0] busy = {busy_w1, busy_p2, busy_p1};

    int errors = 0;
    int checks = 0;

    logic [31:0]  exp_fetch[$];
    logic [2:0]   fetch_mask[$];
    logic [31:0]  xf_addr[$];
    logic [127:0] xf_data[$];
    logic [2:0]   xf_mask[$];

    int   ptr_m = 0;
    bit   auto_mem = 1'b0;
    int   force_stall = -1;
    int   force_vdly = -1;
    bit   chk_pend = 1'b0;
    logic [2:0] mask_pend = '0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Service order from first principles: nearest pending at/after pointer.
    function automatic void plan(input logic [2:0] m, input logic [31:0] a0,
                                 input logic [31:0] a1, input logic [31:0] a2);
        logic [31:0] a [3];
        logic [2:0]  rem;
        logic [2:0]  clr;
        int          s;
        a[0] = a0; a[1] = a1; a[2] = a2;
        rem = m;
        while (rem != 0) begin
            s = ptr_m;
            while (!rem[s]) s = (s + 1) % 3;
            clr = 3'b001 << s;
`ifdef REFILL_MERGE_EN
            for (int j = 0; j < 3; j++)
                if (rem[j] && a[j][31:4] == a[s][31:4]) clr[j] = 1'b1;
`endif
            exp_fetch.push_back({a[s][31:4], 4'h0});
            fetch_mask.push_back(clr);
            rem   = rem & ~clr;
            ptr_m = (s + 1) % 3;
        end
    endfunction

    task automatic drive(input logic [2:0] m, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [31:0] a2);
        @(negedge clk);
        {miss_w1, miss_p2, miss_p1} = m;
        ma_p1 = a0; ma_p2 = a1; ma_w1 = a2;
        @(negedge clk);
        {miss_w1, miss_p2, miss_p1} = 3'b000;
    endtask

    task automatic issue(input logic [2:0] m, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [31:0] a2);
        plan(m, a0, a1, a2);
        drive(m, a0, a1, a2);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && (busy != 0 || exp_fetch.size() != 0 ||
               xf_addr.size() != 0 || chk_pend)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL idle_timeout actual=busy %b fetches %0d required=idle",
                     busy, exp_fetch.size());
        end
        @(negedge clk);
    endtask

    task automatic outs_zero(input string nm);
        chk(nm, {mem_req, fill_we, busy, mem_addr, fill_addr}, '0);
        chk({nm, "_data"}, fill_data, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1 outs_zero("rst_outputs");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ptr_m = 0;
        exp_fetch.delete(); fetch_mask.delete();
        xf_addr.delete(); xf_data.delete(); xf_mask.delete();
        chk_pend = 1'b0;
    endtask

    // Memory side: checks fetch address/hold, then acks and returns a line.
    initial begin
        mem_ack = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (auto_mem && mem_req) begin
                logic [31:0]  a;
                logic [2:0]   m;
                logic [127:0] d;
                int st, vd;
                if (exp_fetch.size() == 0) begin
                    chk("fetch_unexpected", mem_addr, 0);
                    a = mem_addr; m = 3'b000;
                end else begin
                    a = exp_fetch.pop_front();
                    m = fetch_mask.pop_front();
                    chk("fetch_addr", mem_addr, a);
                end
                st = (force_stall >= 0) ? force_stall : $urandom_range(0, 3);
                vd = (force_vdly >= 0) ? force_vdly : $urandom_range(0, 3);
                repeat (st) begin
                    mem_valid = ($urandom_range(0, 1) == 1);
                    mem_rdata = rnd_line();
                    @(negedge clk);
                    chk("req_hold", {mem_req, mem_addr}, {1'b1, a});
                end
                mem_valid = 1'b0;
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
                repeat (vd) @(negedge clk);
                d = rnd_line();
                mem_rdata = d;
                mem_valid = 1'b1;
                xf_addr.push_back(a);
                xf_data.push_back(d);
                xf_mask.push_back(m);
                @(negedge clk);
                mem_valid = 1'b0;
                mem_rdata = rnd_line();
            end
        end
    end

    // Fill monitor: one-cycle pulse with expected line, then busy drops.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_pend) begin
                chk("fill_pulse", fill_we, 0);
                chk("busy_clear", busy & mask_pend, 0);
                chk_pend = 1'b0;
            end
            if (fill_we) begin
                if (xf_addr.size() == 0) begin
                    chk("fill_unexpected", fill_addr, 0);
                end else begin
                    logic [2:0] m;
                    m = xf_mask.pop_front();
                    chk("fill_addr", fill_addr, xf_addr.pop_front());
                    chk("fill_data", fill_data, xf_data.pop_front());
                    chk("busy_at_fill", busy & m, m);
                    mask_pend = m;
                    chk_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        {miss_w1, miss_p2, miss_p1} = 3'b000;
        ma_p1 = '0; ma_p2 = '0; ma_w1 = '0;
        @(negedge clk);
        outs_zero("reset_state");
        @(negedge clk);
        rst = 1'b1;
        auto_mem = 1'b1;

        force_stall = 0; force_vdly = 0;
        plan(3'b001, 32'h0000_1234, 0, 0);
        @(negedge clk);
        miss_p1 = 1'b1; ma_p1 = 32'h0000_1234;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                miss_p1 = 1'b0;
                chk("lat_busy_c1", busy_p1, 1);
            end
            if (c == 2) chk("lat_req_c2", {mem_req, mem_addr}, {1'b1, 32'h0000_1230});
            if (c == 3) chk("lat_nofill_c3", fill_we, 0);
            if (c == 4) chk("lat_fill_c4", fill_we, 1);
            if (c == 5) chk("lat_busy_c5", busy_p1, 0);
        end
        wait_idle(50);

        do_reset();
        issue(3'b111, 32'h100, 32'h200, 32'h300);
        wait_idle(100);

        issue(3'b110, 32'h0, 32'h440, 32'h44C);
        wait_idle(100);

        force_stall = 5;
        issue(3'b100, 32'h0, 32'h0, 32'hABCD_0128);
        wait_idle(100);
        force_stall = -1; force_vdly = -1;

        auto_mem = 1'b0;
        drive(3'b100, 32'h0, 32'h0, 32'h0000_5550);
        begin
            int n = 0;
            while (!mem_req && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        chk("wr_req_seen", mem_req, 1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        rst = 1'b0;
        #1 outs_zero("rst_in_wait");
        @(negedge clk);
        rst = 1'b1;
        ptr_m = 0;
        mem_rdata = rnd_line();
        mem_valid = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("late_valid_quiet", {fill_we, mem_req, busy}, 0);
        end
        auto_mem = 1'b1;

        do_reset();
        exp_fetch.push_back(32'h1000); fetch_mask.push_back(3'b001);
        exp_fetch.push_back(32'h2000); fetch_mask.push_back(3'b010);
        exp_fetch.push_back(32'h3000); fetch_mask.push_back(3'b001);
        ptr_m = 1;
        drive(3'b011, 32'h1000, 32'h2000, 32'h0);
        begin
            int n = 0;
            while (busy_p1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("rr_p1_cleared", busy_p1, 0);
        end
        chk("rr_p2_still_pending", busy_p2, 1);
        miss_p1 = 1'b1; ma_p1 = 32'h3004;
        @(negedge clk);
        miss_p1 = 1'b0;
        wait_idle(100);

        repeat (40) begin
            logic [2:0]  m;
            logic [31:0] base;
            logic [31:0] a [3];
            m = 3'($urandom_range(1, 7));
            base = $urandom;
            for (int k = 0; k < 3; k++)
                a[k] = ($urandom_range(0, 1) == 1) ?
                       {base[31:4], 4'($urandom)} : $urandom;
            issue(m, a[0], a[1], a[2]);
            wait_idle(200);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
